// File: rtl/serializador_con_idle.sv
// rtl/serializador_con_idle.sv - MSB-first byte serializer with K28.5 idle fill and reset preamble
// Optional even-parity bit per symbol when SERIAL_PARITY_EN is defined.
module serializador_con_idle #(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] IDLE_SYMBOL  = 8'hBC,
  parameter int               SYNC_SYMBOLS = 2
) (
  input  logic             CLK,
  input  logic             RESET_L,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic             OUT_SERIAL,
  output logic             OUT_FRAME,
  output logic             OUT_IDLE
);

`ifdef SERIAL_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int             BC_W    = $clog2(FRAME_LEN);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(FRAME_LEN - 1);
  localparam logic [3:0]      SC_LAST = 4'(SYNC_SYMBOLS - 1);

  typedef enum logic {SYNC, ACTIVE} state_t;

  state_t          state, state_n;
  logic [WIDTH-1:0] sh, sh_n;
  logic [BC_W-1:0]  bc, bc_n;
  logic [3:0]       sc, sc_n;
  logic             idle, idle_n;
  logic             at_boundary;
  logic             ready;
`ifdef SERIAL_PARITY_EN
  logic             par, par_n;
`endif

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state <= SYNC;
      sh    <= IDLE_SYMBOL;
      bc    <= '0;
      sc    <= '0;
      idle  <= 1'b1;
`ifdef SERIAL_PARITY_EN
      par   <= ^IDLE_SYMBOL;
`endif
    end else begin
      state <= state_n;
      sh    <= sh_n;
      bc    <= bc_n;
      sc    <= sc_n;
      idle  <= idle_n;
`ifdef SERIAL_PARITY_EN
      par   <= par_n;
`endif
    end
  end

  always_comb begin
    at_boundary = (bc == BC_LAST);
    ready       = at_boundary && (state == ACTIVE || sc == SC_LAST);
    state_n     = state;
    sh_n        = {sh[WIDTH-2:0], 1'b0};
    bc_n        = bc + BC_W'(1);
    sc_n        = sc;
    idle_n      = idle;
`ifdef SERIAL_PARITY_EN
    par_n       = par;
`endif
    if (at_boundary) begin
      bc_n = '0;
      if (ready && IN_VALID) begin
        sh_n   = IN_DATA;
        idle_n = 1'b0;
`ifdef SERIAL_PARITY_EN
        par_n  = ^IN_DATA;
`endif
      end else begin
        sh_n   = IDLE_SYMBOL;
        idle_n = 1'b1;
`ifdef SERIAL_PARITY_EN
        par_n  = ^IDLE_SYMBOL;
`endif
      end
      // sc only counts preamble symbols; ACTIVE never returns to SYNC
      if (state == SYNC) begin
        sc_n = sc + 4'd1;
        if (sc == SC_LAST) state_n = ACTIVE;
      end
    end
  end

  assign IN_READY  = ready;
  assign OUT_FRAME = (bc == '0);
  assign OUT_IDLE  = idle;
`ifdef SERIAL_PARITY_EN
  assign OUT_SERIAL = (bc == BC_W'(WIDTH)) ? par : sh[WIDTH-1];
`else
  assign OUT_SERIAL = sh[WIDTH-1];
`endif

endmodule

// File: tb/tb_serializador_con_idle.sv
// tb/tb_serializador_con_idle.sv - directed and random checks of serializador_con_idle against a frame-arithmetic model
module tb_serializador_con_idle;
  localparam int         W    = 8;
  localparam logic [7:0] IDLE = 8'hBC;
  localparam int         SYNC = 2;
`ifdef SERIAL_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic       CLK = 1'b0;
  logic       RESET_L = 1'b0;
  logic [7:0] IN_DATA = 8'h00;
  logic       IN_VALID = 1'b0;
  logic       IN_READY, OUT_SERIAL, OUT_FRAME, OUT_IDLE;

  serializador_con_idle #(.WIDTH(W), .IDLE_SYMBOL(IDLE), .SYNC_SYMBOLS(SYNC)) dut (
    .CLK(CLK), .RESET_L(RESET_L), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID),
    .IN_READY(IN_READY), .OUT_SERIAL(OUT_SERIAL), .OUT_FRAME(OUT_FRAME), .OUT_IDLE(OUT_IDLE)
  );

  always #5 CLK = ~CLK;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          t;
  logic [7:0]  cur_sym;
  logic        cur_idle;
  logic [31:0] cap;
  int          first_ready;
  int          acc_cycle;
  logic        took;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s t=%0d observed=%b expected=%b", tag, t, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bit-clock cycle: expected outputs follow from position within the frame stream
  task automatic cyc(input logic v, input logic [7:0] d);
    int   pos, f;
    logic er, es;
    IN_VALID = v;
    IN_DATA  = d;
    pos = t % FL;
    f   = t / FL;
    er  = (pos == FL - 1) && (f >= SYNC - 1);
    es  = (pos < W) ? cur_sym[W-1-pos] : ^cur_sym;
    took = 1'b0;
    @(negedge CLK);
    chk("ready", IN_READY, er);
    chk("serial", OUT_SERIAL, es);
    chk("frame", OUT_FRAME, pos == 0);
    chk("idle", OUT_IDLE, cur_idle);
    if (!cur_idle && pos < W) cap = {cap[30:0], OUT_SERIAL};
    if (er && first_ready < 0) first_ready = t;
    @(posedge CLK);
    #1;
    if (pos == FL - 1) begin
      if (er && v) begin
        cur_sym = d; cur_idle = 1'b0; acc_cycle = t; took = 1'b1;
      end else begin
        cur_sym = IDLE; cur_idle = 1'b1;
      end
    end
    t++;
  endtask

  task automatic do_reset();
    RESET_L  = 1'b0;
    IN_VALID = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_serial", OUT_SERIAL, IDLE[W-1]);
    chk("rst_frame", OUT_FRAME, 1'b1);
    chk("rst_idle", OUT_IDLE, 1'b1);
    chk("rst_ready", IN_READY, 1'b0);
    RESET_L     = 1'b1;
    t           = 0;
    cur_sym     = IDLE;
    cur_idle    = 1'b1;
    first_ready = -1;
    acc_cycle   = -1;
  endtask

  task automatic send(input logic [7:0] d);
    int guard = 0;
    do begin
      cyc(1'b1, d);
      guard++;
    end while (!took && guard < 4 * FL);
    chk("send_accepted", took, 1'b1);
  endtask

  initial begin
    int prev_acc, start_t, guard;
    logic [7:0] rb;
    logic holding;
    cap = '0;

    // idle preamble and steady idle stream
    do_reset();
    repeat (40) cyc(1'b0, 8'h00);
    chkv("first_ready_idle", first_ready, SYNC * FL - 1);

    // data offered from release: accepted only at the end of the preamble
    do_reset();
    send(8'hA5);
    chkv("a5_accept_cycle", acc_cycle, SYNC * FL - 1);
    repeat (FL) cyc(1'b0, 8'h00);
    chkv("a5_bits", cap[7:0], 8'hA5);

    // back-to-back symbols with no gap
    send(8'h3C);
    prev_acc = acc_cycle;
    send(8'hFF);
    chkv("b2b_spacing", acc_cycle - prev_acc, FL);
    repeat (FL) cyc(1'b0, 8'h00);
    chkv("b2b_bits", cap[15:0], 16'h3CFF);

    // data raised mid-symbol waits for the next boundary
    guard = 0;
    while ((t % FL) != 3 && guard < 2 * FL) begin cyc(1'b0, 8'h00); guard++; end
    start_t = t;
    send(8'h01);
    chkv("mid_accept_cycle", acc_cycle, start_t + (FL - 1 - 3));
    repeat (FL) cyc(1'b0, 8'h00);
    chkv("mid_bits", cap[7:0], 8'h01);

    // asynchronous reset in the middle of a data symbol
    send(8'h5A);
    repeat (5) cyc(1'b0, 8'h00);
    #2;
    RESET_L = 1'b0;
    #1;
    chk("async_serial", OUT_SERIAL, IDLE[W-1]);
    chk("async_frame", OUT_FRAME, 1'b1);
    chk("async_idle", OUT_IDLE, 1'b1);
    chk("async_ready", IN_READY, 1'b0);
    do_reset();
    repeat (40) cyc(1'b0, 8'h00);
    chkv("first_ready_after_rst", first_ready, SYNC * FL - 1);

    // random traffic, bytes held until accepted
    holding = 1'b0;
    rb = 8'h00;
    for (int i = 0; i < 400; i++) begin
      if (!holding && ($urandom % 3) != 0) begin
        holding = 1'b1;
        rb = 8'($urandom);
      end
      cyc(holding, rb);
      if (took) holding = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
